// File: rtl/axi_ic_pkg.sv
// Shared definitions for the 4-master AXI interconnect: master count,
// read-path state encoding and the one-hot to index helper.
package axi_ic_pkg;

   localparam int NUM_M = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } rd_state_e;

   // OR-reduction encode: exact for one-hot, 0 for an all-zero vector.
   function automatic logic [1:0] onehot2idx(input logic [NUM_M-1:0] oh);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (oh[i]) begin
            idx = idx | 2'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/axi_onehot_mux.sv
// Four-input one-hot mux of width W; a zero select yields an all-zero output.
module axi_onehot_mux
   import axi_ic_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [NUM_M*W-1:0] in_flat,
   input  logic [NUM_M-1:0]   sel,
   output logic [W-1:0]       out
);

   always_comb begin
      out = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (sel[i]) begin
            out = out | in_flat[i*W +: W];
         end
      end
   end

endmodule

// File: rtl/axi_rd_grant_mux.sv
// Read-channel grant holder and router: latches the arbiter's selection,
// routes that master's AR to the slave and its R beats back until RLAST.
module axi_rd_grant_mux
   import axi_ic_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int ID_W   = 4,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_M-1:0]        m_arvalid,
   output logic [NUM_M-1:0]        m_arready,
   input  logic [NUM_M*ADDR_W-1:0] m_araddr,
   input  logic [NUM_M*ID_W-1:0]   m_arid,
   input  logic [NUM_M*LEN_W-1:0]  m_arlen,
   output logic [NUM_M-1:0]        m_rvalid,
   input  logic [NUM_M-1:0]        m_rready,
   output logic [DATA_W-1:0]       m_rdata,
   output logic [ID_W-1:0]         m_rid,
   output logic                    m_rlast,
   output logic                    s_arvalid,
   input  logic                    s_arready,
   output logic [ADDR_W-1:0]       s_araddr,
   output logic [ID_W-1:0]         s_arid,
   output logic [LEN_W-1:0]        s_arlen,
   input  logic                    s_rvalid,
   output logic                    s_rready,
   input  logic [DATA_W-1:0]       s_rdata,
   input  logic [ID_W-1:0]         s_rid,
   input  logic                    s_rlast,
   output logic [NUM_M-1:0]        arb_req,
   input  logic [NUM_M-1:0]        arb_sel,
   output logic                    busy,
   output logic [1:0]              grant_idx
);

   rd_state_e        state_q, state_d;
   logic [NUM_M-1:0] grant_q, grant_d;
   logic [NUM_M-1:0] mux_sel;
   logic             ar_fire;
   logic             r_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ar_fire   = 1'b0;
      r_done    = 1'b0;
      arb_req   = '0;
      s_arvalid = 1'b0;
      m_arready = '0;
      m_rvalid  = '0;
      s_rready  = 1'b0;
      m_rdata   = '0;
      m_rid     = '0;
      m_rlast   = 1'b0;
      case (state_q)
         IDLE: begin
            // A request with no selection simply waits; arbitration is external.
            arb_req = m_arvalid;
            if (|arb_sel) begin
               grant_d = arb_sel;
               state_d = ADDR;
            end
         end
         ADDR: begin
            ar_fire   = |(m_arvalid & grant_q) & s_arready;
            s_arvalid = |(m_arvalid & grant_q);
            m_arready = grant_q & {NUM_M{s_arready}};
            if (ar_fire) begin
               state_d = DATA;
            end
         end
         DATA: begin
            r_done   = s_rvalid & (|(m_rready & grant_q)) & s_rlast;
            m_rvalid = grant_q & {NUM_M{s_rvalid}};
            s_rready = |(m_rready & grant_q);
            m_rdata  = s_rdata;
            m_rid    = s_rid;
            m_rlast  = s_rlast;
            if (r_done) begin
               grant_d = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // AR payload is only driven while the address phase is in progress.
   assign mux_sel   = (state_q == ADDR) ? grant_q : '0;
   assign busy      = (state_q != IDLE);
   assign grant_idx = onehot2idx(grant_q);

   axi_onehot_mux #(.W(ADDR_W)) u_mux_araddr (
      .in_flat (m_araddr),
      .sel     (mux_sel),
      .out     (s_araddr)
   );

   axi_onehot_mux #(.W(ID_W)) u_mux_arid (
      .in_flat (m_arid),
      .sel     (mux_sel),
      .out     (s_arid)
   );

   axi_onehot_mux #(.W(LEN_W)) u_mux_arlen (
      .in_flat (m_arlen),
      .sel     (mux_sel),
      .out     (s_arlen)
   );

endmodule
